// File: rtl/seq_add_subtractor_if.sv
// Operand/result bundle for seq_add_subtractor.
// master = requester (CPU datapath / bench), slave = the adder itself.
interface seq_add_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic             carry_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sat;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output start, op, carry_in, a, b, sat,
        input  busy, done, r, carry, overflow, zero, negative
    );

    modport slave (
        input  start, op, carry_in, a, b, sat,
        output busy, done, r, carry, overflow, zero, negative
    );
endinterface

// File: rtl/seq_add_subtractor.sv
// Multi-cycle add/subtract: SLICE bits per clock, carry chained through a
// register, ADD/SUB/ADC/SBC with a start/busy/done handshake and C/V/Z/N flags.
// Optional build macro SEQ_ADD_SUBTRACTOR_SATURATE_EN clamps r on signed
// overflow when the latched sat bit is set.
module seq_add_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic                  clk,
    input logic                  reset,
    seq_add_subtractor_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, r_q;
    logic             cy_q, carry_q, ovf_q, zero_q, neg_q, busy_q, done_q;
    logic             sat_q;

    int               idx;
    logic [SLICE-1:0] sa, sb;
    logic [SLICE:0]   sum_d;
    logic [WIDTH-1:0] acc_d, res_d;
    logic             cmsb_d, ovf_d;

    // Current slice sum and the candidate final result for the last slice.
    always_comb begin
        idx    = int'(cnt_q) * SLICE;
        sa     = a_q[idx +: SLICE];
        sb     = b_q[idx +: SLICE];
        sum_d  = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, cy_q};
        acc_d  = acc_q;
        acc_d[idx +: SLICE] = sum_d[SLICE-1:0];
        // carry into the top bit recovered from the top bit's sum equation
        cmsb_d = sa[SLICE-1] ^ sb[SLICE-1] ^ sum_d[SLICE-1];
        ovf_d  = cmsb_d ^ sum_d[SLICE];
        res_d  = acc_d;
`ifdef SEQ_ADD_SUBTRACTOR_SATURATE_EN
        // clamp toward the sign of the true result: no carry -> positive
        if (sat_q && ovf_d)
            res_d = sum_d[SLICE] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

`ifndef SEQ_ADD_SUBTRACTOR_SATURATE_EN
    // sat is latched but has no effect in the wrapping build
    logic sat_unused;
    assign sat_unused = sat_q;
`endif

    // Control FSM with registered outputs; start sampled only in IDLE/DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            cy_q    <= 1'b0;
            sat_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b ^ {WIDTH{bus.op[0]}};
                        cy_q    <= bus.op[1] ? bus.carry_in : bus.op[0];
                        sat_q   <= bus.sat;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cy_q  <= sum_d[SLICE];
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        r_q     <= res_d;
                        carry_q <= sum_d[SLICE];
                        ovf_q   <= ovf_d;
                        zero_q  <= (res_d == '0);
                        neg_q   <= res_d[WIDTH-1];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.r        = r_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;
endmodule

// File: tb/tb_seq_add_subtractor.sv
// Bench for seq_add_subtractor (WIDTH=16, SLICE=4). Expectations adjust to
// SEQ_ADD_SUBTRACTOR_SATURATE_EN when that macro is defined for the build.
module tb_seq_add_subtractor;
    localparam int W  = 16;
    localparam int S  = 4;
    localparam int NS = W / S;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    seq_add_subtractor_if #(.WIDTH(W)) bus ();

    seq_add_subtractor #(.WIDTH(W), .SLICE(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    logic         m_busy = 0, m_done = 0, m_c = 0, m_v = 0, m_z = 0, m_n = 0;
    logic [W-1:0] m_r = '0;
    logic [W-1:0] p_r;
    logic         p_c, p_v;
    int           left = 0;

    // whole-word arithmetic on the operands present when start is accepted
    task automatic calc(input logic [1:0] op, input logic cin, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sat);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         c0;
        bb   = op[0] ? ~b : b;
        c0   = op[1] ? cin : op[0];
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        p_r  = full[W-1:0];
        p_c  = full[W];
        p_v  = (a[W-1] == bb[W-1]) && (p_r[W-1] != a[W-1]);
`ifdef SEQ_ADD_SUBTRACTOR_SATURATE_EN
        if (sat && p_v) p_r = p_c ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
        if (sat) p_r = p_r;
`endif
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            left = 0; m_busy = 0; m_done = 0;
            m_r = '0; m_c = 0; m_v = 0; m_z = 0; m_n = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                m_r = p_r; m_c = p_c; m_v = p_v;
                m_z = (p_r == '0); m_n = p_r[W-1];
                m_busy = 0; m_done = 1;
            end
        end else begin
            m_done = 0;
            if (bus.start) begin
                calc(bus.op, bus.carry_in, bus.a, bus.b, bus.sat);
                left = NS;
                m_busy = 1;
            end
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, m_done);
        chk("r", bus.r, m_r);
        chk("carry", bus.carry, m_c);
        chk("overflow", bus.overflow, m_v);
        chk("zero", bus.zero, m_z);
        chk("negative", bus.negative, m_n);
    end

    // ---------------- stimulus ----------------
    task automatic scramble();
        bus.a = W'($urandom); bus.b = W'($urandom);
        bus.op = 2'($urandom); bus.carry_in = 1'($urandom); bus.sat = 1'($urandom);
    endtask

    // Issue one op at a negedge, wait (bounded) for done; returns at the done negedge.
    task automatic do_op(input logic [1:0] op, input logic cin, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sat, input bit mid_start,
                         output int lat, output int bcnt);
        int s;
        bus.op = op; bus.carry_in = cin; bus.a = a; bus.b = b; bus.sat = sat;
        bus.start = 1'b1;
        s = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
        lat = -1; bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin lat = cyc - s; break; end
            bus.start = (mid_start && i == 1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, bc, d1, d2;
        bus.start = 0; bus.op = 0; bus.carry_in = 0; bus.a = 0; bus.b = 0; bus.sat = 0;
        #1;
        chk("rst_r", bus.r, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_flags", {bus.carry, bus.overflow, bus.zero, bus.negative}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ADD with latency / busy width
        do_op(2'b00, 0, 16'h1234, 16'h0FCD, 0, 0, lat, bc);
        chk("add_r", bus.r, 16'h2201);
        chk("add_flags", {bus.carry, bus.overflow, bus.zero, bus.negative}, 4'b0000);
        chk("add_latency", lat, NS + 1);
        chk("add_busy_cycles", bc, NS);

        // SUB with and without borrow
        do_op(2'b01, 0, 16'h0005, 16'h0007, 0, 0, lat, bc);
        chk("sub1_r", bus.r, 16'hFFFE);
        chk("sub1_cvn", {bus.carry, bus.overflow, bus.negative}, 3'b001);
        do_op(2'b01, 0, 16'h0007, 16'h0005, 0, 0, lat, bc);
        chk("sub2_r", bus.r, 16'h0002);
        chk("sub2_carry", bus.carry, 1);

        // overflow with sat request
        do_op(2'b00, 0, 16'h7FFF, 16'h0001, 1, 0, lat, bc);
`ifdef SEQ_ADD_SUBTRACTOR_SATURATE_EN
        chk("sat_add_r", bus.r, 16'h7FFF);
        chk("sat_add_vn", {bus.overflow, bus.negative}, 2'b10);
`else
        chk("sat_add_r", bus.r, 16'h8000);
        chk("sat_add_vn", {bus.overflow, bus.negative}, 2'b11);
`endif
        do_op(2'b01, 0, 16'h8000, 16'h0001, 1, 0, lat, bc);
`ifdef SEQ_ADD_SUBTRACTOR_SATURATE_EN
        chk("sat_sub_r", bus.r, 16'h8000);
`else
        chk("sat_sub_r", bus.r, 16'h7FFF);
`endif
        chk("sat_sub_v", bus.overflow, 1);

        // chained 32-bit style sequence
        do_op(2'b00, 0, 16'hFFFF, 16'h0001, 0, 0, lat, bc);
        chk("chain_lo_r", bus.r, 16'h0000);
        chk("chain_lo_cz", {bus.carry, bus.zero}, 2'b11);
        do_op(2'b10, 1, 16'h0000, 16'h0000, 0, 0, lat, bc);
        chk("adc_r", bus.r, 16'h0001);
        do_op(2'b11, 0, 16'h0000, 16'h0000, 0, 0, lat, bc);
        chk("sbc_r", bus.r, 16'hFFFF);
        chk("sbc_carry", bus.carry, 0);
        @(negedge clk);

        // reset two cycles into RUN
        bus.op = 2'b00; bus.a = 16'h0101; bus.b = 16'h0202; bus.start = 1;
        @(negedge clk); bus.start = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_r", bus.r, 0);
        chk("midrst_bd", {bus.busy, bus.done}, 2'b00);
        chk("midrst_flags", {bus.carry, bus.overflow, bus.zero, bus.negative}, 0);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_done", bus.done, 0);
        end

        // start pulsed mid-RUN is ignored
        do_op(2'b00, 0, 16'h1111, 16'h2222, 0, 1, lat, bc);
        chk("midstart_r", bus.r, 16'h3333);
        chk("midstart_latency", lat, NS + 1);
        @(negedge clk);

        // start held high through DONE: back-to-back
        bus.op = 2'b00; bus.a = 16'h0001; bus.b = 16'h0002; bus.start = 1;
        @(negedge clk);
        bus.a = 16'h0010; bus.b = 16'h0020;
        d1 = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin d1 = cyc; break; end
            @(negedge clk);
        end
        chk("b2b_first_r", bus.r, 16'h0003);
        @(negedge clk); bus.start = 0;
        chk("b2b_no_gap_busy", bus.busy, 1);
        chk("b2b_r_held", bus.r, 16'h0003);
        d2 = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin d2 = cyc; break; end
            @(negedge clk);
        end
        chk("b2b_second_r", bus.r, 16'h0030);
        chk("b2b_spacing", d2 - d1, NS + 1);
        if (d1 < 0 || d2 < 0) chk("b2b_timeout", 0, 1);

        // randomized ops with random gaps (gap 0 exercises start in DONE)
        for (int n = 0; n < 200; n++) begin
            do_op(2'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0), lat, bc);
            chk("rand_latency", lat, NS + 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seq_add_subtractor.md
Name: seq_add_subtractor

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit ripple adder/subtractor.
- Adds or subtracts two WIDTH-bit operands, SLICE bits per clock, carrying between slices in a register.
- Adds carry-in ops (ADC/SBC), a start/busy/done handshake and a full flag set (carry, overflow, zero, negative).
- Used by the CPU datapath where a wide, narrow-area adder is acceptable at multi-cycle latency.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE and at least 2.
- SLICE, 4, bits processed per RUN cycle; 1 <= SLICE <= WIDTH.
- NSLICE, WIDTH/SLICE, derived (localparam), number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled in IDLE or DONE only.
- op  in  2  operation: 00 ADD a+b; 01 SUB a-b; 10 ADC a+b+carry_in; 11 SBC a+~b+carry_in.
- carry_in  in  1  carry for ADC/SBC; 1 = no borrow for SBC.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sat  in  1  per-operation saturate request; see Optional Feature.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- r  out  WIDTH  result.
- carry  out  1  final carry out (SUB/SBC: 1 = no borrow).
- overflow  out  1  signed overflow.
- zero  out  1  r == 0.
- negative  out  1  r[WIDTH-1].

Behaviour:
- Reset:
  - Asynchronous, active-high, any time including mid-operation.
  - State = IDLE; r, carry, overflow, zero, negative, busy, done all = 0.
  - Partial result discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
  - IDLE, start=1 -> RUN.
  - RUN -> RUN while the slice counter is below NSLICE-1; -> DONE after slice NSLICE-1.
  - DONE, start=1 -> RUN; otherwise DONE -> IDLE.
- Start edge:
  - Latch a, b' = b XOR {WIDTH{op[0]}}, and sat.
  - Initial carry: ADD 0, SUB 1, ADC/SBC carry_in.
  - Slice counter = 0.
- RUN cycle k (k = 0..NSLICE-1):
  - Add slice bits [k*SLICE +: SLICE] of a and b' plus the carry register.
  - Write the sum into the internal accumulator; update the carry register.
  - On the last slice, capture carry into MSB (c_msb) and carry out.
- Completion edge (end of RUN slice NSLICE-1):
  - r <= accumulator.
  - carry <= final carry.
  - overflow <= c_msb XOR final carry.
  - zero and negative computed from the value loaded into r.
- Latency: start sampled at edge E0; busy=1 for NSLICE cycles; done=1 in cycle NSLICE+1 after E0 (5 cycles for the defaults).
- r and flags:
  - Change only on a completion edge.
  - Hold their last value through IDLE and through a following RUN.
- start during RUN is ignored. Input changes during RUN do not affect the result.
- Back-to-back: start=1 in DONE is accepted; done drops, busy rises the next cycle. No idle gap required.
- SLICE == WIDTH: NSLICE=1, single RUN cycle, done 2 cycles after start.
- Wrap-around is modulo 2^WIDTH; no exceptions are raised.

Optional Feature:
- Macro: SEQ_ADD_SUBTRACTOR_SATURATE_EN.
- With the macro defined:
  - If the latched sat=1 and overflow=1, r is clamped on the completion edge.
  - Clamp value: 0 1...1 (max positive) when the true result is positive (final carry=0), 1 0...0 (min negative) otherwise.
  - overflow still reads 1; carry is unclamped.
  - zero and negative reflect the clamped r.
- Without the macro: the sat port exists but is ignored; r always wraps.

Test Plan:
- WIDTH=16, SLICE=4: ADD 0x1234 + 0x0FCD -> r=0x2201, carry=0, overflow=0, zero=0, negative=0; busy high exactly 4 cycles; done pulse exactly 5 cycles after the start edge.
- SUB 0x0005 - 0x0007 -> r=0xFFFE, carry=0, negative=1, overflow=0. Then SUB 0x0007 - 0x0005 -> r=0x0002, carry=1.
- ADD 0x7FFF + 0x0001, sat=1:
  - Macro undefined -> r=0x8000, overflow=1, negative=1.
  - Macro defined -> r=0x7FFF, overflow=1, negative=0.
  - SUB 0x8000 - 0x0001, sat=1, macro defined -> r=0x8000, overflow=1.
- Chained 32-bit add:
  - ADD 0xFFFF + 0x0001 -> r=0x0000, carry=1, zero=1.
  - Then ADC 0x0000 + 0x0000 with carry_in=1 -> r=0x0001.
  - SBC 0x0000 + ~0x0000 with carry_in=0 -> r=0xFFFF, carry=0.
- Assert reset 2 cycles into RUN -> all outputs 0 immediately, state IDLE, no done pulse. A start pulsed mid-RUN in a separate run is ignored; the result matches the original operands.
- Start held high through DONE -> second operation accepted with no idle cycle; two done pulses 5 cycles apart; first r held until the second completion edge.
